// File: rtl/aes_subshift_serial.sv
// AES SubBytes followed by ShiftRows on a 128-bit state.
// S-box lookups are serialised over 16/BPC cycles, with a valid/ready handshake on each side.
module aes_subshift_serial #(
  parameter int unsigned BPC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_state,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_state,
  output logic         busy
);

  localparam int unsigned STATE_W = 128;
  localparam int unsigned K_W     = 4;
  localparam logic [K_W-1:0] K_LAST = K_W'(16 - BPC);
  localparam logic [K_W-1:0] K_STEP = K_W'(BPC);

  generate
    if (!(BPC == 1 || BPC == 2 || BPC == 4 || BPC == 8 || BPC == 16)) begin : g_bad_bpc
      $error("aes_subshift_serial: BPC must be 1, 2, 4, 8 or 16");
    end
  endgenerate

  // FIPS-197 forward S-box; entry x sits at bits [8*(255-x) +: 8]
  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX[8*(255 - int'(x)) +: 8];
  endfunction

  // Source byte (row r, column cs) lands in column (cs - r) mod 4 of the same row
  function automatic logic [K_W-1:0] dest_of(input logic [K_W-1:0] src);
    return {src[3:2] - src[1:0], src[1:0]};
  endfunction

  typedef enum logic [1:0] {IDLE, SUB, DONE} state_e;

  state_e             state_q, state_d;
  logic [K_W-1:0]     k_q, k_d;
  logic [STATE_W-1:0] cap_q, cap_d;
  logic [STATE_W-1:0] res_q, res_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      k_q       <= '0;
      cap_q     <= '0;
      res_q     <= '0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      cap_q     <= cap_d;
      res_q     <= res_d;
      in_ready  <= (state_d == IDLE);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
    end
  end

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    cap_d   = cap_q;
    res_d   = res_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          cap_d   = in_state;
          k_d     = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        for (int l = 0; l < int'(BPC); l++) begin
          res_d[8*(15 - int'(dest_of(k_q + K_W'(l)))) +: 8] =
            sbox(cap_q[8*(15 - int'(k_q + K_W'(l))) +: 8]);
        end
        // Hold k on the final group so it never wraps past 15
        if (k_q == K_LAST) state_d = DONE;
        else               k_d     = k_q + K_STEP;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign out_state = res_q;

endmodule

// File: doc/aes_subshift_serial.md
AES_SUBSHIFT_SERIAL -- requirements
Module: aes_subshift_serial

Interface
REQ-001 SHALL have parameter: BPC, 1, S-box lookups per cycle during substitution; legal values 1, 2, 4, 8, 16; other values SHALL fail elaboration.
REQ-002 SHALL have port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 SHALL have port: rst  input  1  synchronous active-high reset, sampled on rising clk edge.
REQ-004 SHALL have port: in_valid  input  1  upstream offers in_state.
REQ-005 SHALL have port: in_ready  output  1  block can accept a new state.
REQ-006 SHALL have port: in_state  input  128  AES state, column-major; byte i = row + 4*col at bits [127-8i -: 8].
REQ-007 SHALL have port: out_valid  output  1  out_state holds a finished result.
REQ-008 SHALL have port: out_ready  input  1  downstream (MixColumns/round register) accepts out_state.
REQ-009 SHALL have port: out_state  output  128  SubBytes then ShiftRows of the accepted state, same byte ordering.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.

Function
REQ-011 SHALL compute out byte (r + 4c) = S(in byte (r + 4*((c+r) mod 4))), r,c in 0..3, S = FIPS-197 forward S-box; S-box realisation is free but SHALL match the table bit-exactly.
REQ-012 SHALL implement FSM states IDLE, SUB, DONE; one-hot or encoded is free.
REQ-013 IDLE: in_ready=1, out_valid=0; in_valid=1 at an edge captures in_state into an internal register, clears byte counter k to 0, moves to SUB.
REQ-014 SUB: in_ready=0, out_valid=0; each edge substitutes bytes k..k+BPC-1 of the captured state into their ShiftRows destinations in the result register, then k += BPC.
REQ-015 SUB SHALL last exactly 16/BPC cycles; the edge processing the last group (k = 16-BPC) moves to DONE and sets out_valid=1.
REQ-016 Latency: with accept at edge E0, out_valid SHALL be high immediately after edge E(16/BPC) (BPC=1: after E16).
REQ-017 DONE: out_valid=1, in_ready=0; out_state SHALL hold stable until an edge with out_ready=1, which moves to IDLE and clears out_valid.
REQ-018 No overlap: a new input SHALL NOT be accepted in the same edge as the output handshake; in_ready rises in the cycle after DONE exits.
REQ-019 in_state SHALL be sampled only at the accept edge; later changes to in_state SHALL NOT affect the result.
REQ-020 in_valid while in_ready=0 SHALL be ignored (no capture, no state change).
REQ-021 Counter k SHALL be 4 bits and SHALL NOT wrap past 15 within one operation; it is reset to 0 on every accept.
REQ-022 out_state outside DONE is don't-care to the consumer but SHALL be deterministic (reset value or last result).

Reset
REQ-023 rst=1 at an edge SHALL force IDLE, k=0, out_valid=0, busy=0, out_state=128'h0, capture register=128'h0; in_ready=1 after that edge.
REQ-024 rst SHALL take priority over in_valid, out_ready and FSM progress in the same edge.
REQ-025 rst during SUB or DONE SHALL discard the partial/finished result; no out_valid pulse SHALL follow.

Verification
REQ-026 FIPS-197 App. B round 1: in_state=193de3bea0f4e22b9ac68d2ae9f84808, out_ready=1 -> out_state=d4bf5d30e0b452aeb84111f11e2798e5, out_valid first high 16 cycles after accept (BPC=1), 1 cycle for BPC=16.
REQ-027 in_state=128'h0 -> out_state=636363...63 (all 0x63); in_state all 0x01 -> all 0x7c.
REQ-028 Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_valid and out_state stable for all 10, in_ready=0 throughout, pulsing in_valid with other data changes nothing.
REQ-029 Reset mid-operation: assert rst at SUB cycle 7 -> next cycle in_ready=1, out_valid=0, out_state=0; a fresh accept afterwards yields the correct result with full latency.
REQ-030 Back-to-back: in_valid held high with two states, out_ready=1 -> exactly two out_valid pulses, correct results in order, in_ready high for exactly one cycle between operations.
REQ-031 Repeat REQ-026 for BPC = 1, 2, 4, 8, 16 -> identical out_state, latency 16/BPC.
